sram_ring_scheduler: RTL and testbench

SRAM_RING_SCHEDULER -- requirements
Module: sram_ring_scheduler

---
 rtl/sram_ring_scheduler_pkg.sv | 28 ++
 rtl/sram_rr_arbiter.sv | 56 +++++
 rtl/sram_ring_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_sram_ring_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ring_scheduler_pkg.sv
// Shared definitions for the SRAM ring scheduler. This package holds the FSM
// state encoding, the default burst sizes and ring geometry, and a helper
// that sizes the final reads while the ring drains.
package sram_ring_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_WR_WAIT    = 3'd2,
    ST_RD_WAIT    = 3'd3,
    ST_DRAIN_ARB  = 3'd4,
    ST_DRAIN_WAIT = 3'd5
  } state_e;

  localparam int unsigned DEF_WR_BURST          = 1024;
  localparam int unsigned DEF_RD_BURST          = 4096;
  localparam int unsigned DEF_SRAM_DEPTH        = 32768;
  localparam logic [13:0] DEF_USB_FIFO_MAX_USED = 14'h3000;
  localparam int unsigned DEF_WDOG_LIMIT        = 65535;

  // A drain read moves whatever is left, up to one full read burst.
  function automatic logic [14:0] drain_len(input logic [15:0] level,
                                            input int unsigned rd_burst);
    if (32'(level) >= rd_burst) drain_len = 15'(rd_burst);
    else                        drain_len = level[14:0];
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin write/read arbiter for the SRAM ring.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   arb_en_i            high while the scheduler may start a run-mode burst
//   sram_fifo_usedw_i   input FIFO fill (words waiting to be written)
//   usb_fifo_usedw_i    output FIFO fill (space check for reads)
//   level_i             words currently held in the ring
//   wr_grant_o          start a write burst this cycle
//   rd_grant_o          start a read burst this cycle
// When both sides are eligible the side not granted last wins. last_rd_q
// resets to "read" so the first tie goes to the write side.
module sram_rr_arbiter
  import sram_ring_scheduler_pkg::*;
#(
  parameter int unsigned WR_BURST          = DEF_WR_BURST,
  parameter int unsigned RD_BURST          = DEF_RD_BURST,
  parameter int unsigned SRAM_DEPTH        = DEF_SRAM_DEPTH,
  parameter logic [13:0] USB_FIFO_MAX_USED = DEF_USB_FIFO_MAX_USED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        arb_en_i,
  input  logic [10:0] sram_fifo_usedw_i,
  input  logic [13:0] usb_fifo_usedw_i,
  input  logic [15:0] level_i,
  output logic        wr_grant_o,
  output logic        rd_grant_o
);

  logic wr_ok;
  logic rd_ok;
  logic last_rd_q;
  logic last_rd_d;

  // Write needs a full burst waiting and room for all of it in the ring.
  assign wr_ok = (32'(sram_fifo_usedw_i) >= WR_BURST) &&
                 (32'(level_i) + WR_BURST <= SRAM_DEPTH);
  // Read needs a full burst stored and USB FIFO headroom.
  assign rd_ok = (32'(level_i) >= RD_BURST) &&
                 (usb_fifo_usedw_i <= USB_FIFO_MAX_USED);

  assign wr_grant_o = arb_en_i && wr_ok && (!rd_ok || last_rd_q);
  assign rd_grant_o = arb_en_i && rd_ok && (!wr_ok || !last_rd_q);

  always_comb begin
    last_rd_d = last_rd_q;
    if (wr_grant_o)      last_rd_d = 1'b0;
    else if (rd_grant_o) last_rd_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_rd_q <= 1'b1;
    else          last_rd_q <= last_rd_d;
  end

endmodule

// File: rtl/sram_ring_scheduler.sv
// Schedules write and read bursts between an input FIFO, a ring buffer in
// SRAM and a USB output FIFO. Exactly one burst is outstanding at a time.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   iRunStart                       level, acquisition run enable
//   SRAM_FIFO_usedw, USB_FIFO_usedw FIFO fill levels
//   WR_RunEnd, RD_RunEnd            burst-complete pulses from SRAM controller
//   WR_iRunStart, RD_iRunStart      one-cycle burst start pulses
//   WR/RD_START_ADDR, WR/RD_DATA_NUM burst descriptors
//   Data_iRunStart                  data source enable
//   sram_level, sram_empty, sram_full ring occupancy
//   wdog_err                        sticky burst-timeout flag
//   dbg_state_o                     current FSM state
// Burst handshake: a start pulse is high for exactly the first cycle of the
// matching WAIT state, with START_ADDR/DATA_NUM valid from that cycle until
// the next grant of that side. The controller answers with a one-cycle
// RunEnd; a RunEnd seen outside the matching WAIT state is dropped.
module sram_ring_scheduler
  import sram_ring_scheduler_pkg::*;
#(
  parameter int unsigned WR_BURST          = DEF_WR_BURST,
  parameter int unsigned RD_BURST          = DEF_RD_BURST,
  parameter int unsigned SRAM_DEPTH        = DEF_SRAM_DEPTH,
  parameter logic [13:0] USB_FIFO_MAX_USED = DEF_USB_FIFO_MAX_USED,
  parameter int unsigned WDOG_LIMIT        = DEF_WDOG_LIMIT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iRunStart,
  input  logic [10:0] SRAM_FIFO_usedw,
  input  logic [13:0] USB_FIFO_usedw,
  input  logic        WR_RunEnd,
  input  logic        RD_RunEnd,
  output logic        WR_iRunStart,
  output logic        RD_iRunStart,
  output logic [14:0] WR_START_ADDR,
  output logic [14:0] RD_START_ADDR,
  output logic [14:0] WR_DATA_NUM,
  output logic [14:0] RD_DATA_NUM,
  output logic        Data_iRunStart,
  output logic [15:0] sram_level,
  output logic        sram_empty,
  output logic        sram_full,
  output logic        wdog_err,
  output logic [2:0]  dbg_state_o
);

  localparam logic [14:0] WR_NUM = 15'(WR_BURST);
  localparam logic [14:0] RD_NUM = 15'(RD_BURST);

  state_e      state_q, state_d;
  logic [14:0] wr_ptr_q, wr_ptr_d;
  logic [14:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] level_q, level_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic [14:0] wr_num_q, wr_num_d;
  logic [14:0] rd_num_q, rd_num_d;
  logic        wr_start_q, wr_start_d;
  logic        rd_start_q, rd_start_d;
  logic        data_en_q, data_en_d;
  logic        wdog_err_q, wdog_err_d;
  logic [15:0] wdog_cnt_q, wdog_cnt_d;

  logic arb_en;
  logic wr_grant;
  logic rd_grant;
  logic usb_ok;
  logic wdog_trip;

  assign arb_en    = (state_q == ST_ARB) && iRunStart;
  assign usb_ok    = (USB_FIFO_usedw <= USB_FIFO_MAX_USED);
  // Trips on the WDOG_LIMIT-th consecutive cycle spent waiting.
  assign wdog_trip = (32'(wdog_cnt_q) == WDOG_LIMIT - 1);

  sram_rr_arbiter #(
    .WR_BURST          (WR_BURST),
    .RD_BURST          (RD_BURST),
    .SRAM_DEPTH        (SRAM_DEPTH),
    .USB_FIFO_MAX_USED (USB_FIFO_MAX_USED)
  ) u_arb (
    .clk               (clk),
    .reset_n           (reset_n),
    .arb_en_i          (arb_en),
    .sram_fifo_usedw_i (SRAM_FIFO_usedw),
    .usb_fifo_usedw_i  (USB_FIFO_usedw),
    .level_i           (level_q),
    .wr_grant_o        (wr_grant),
    .rd_grant_o        (rd_grant)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_num_d   = wr_num_q;
    rd_num_d   = rd_num_q;
    wr_start_d = 1'b0;
    rd_start_d = 1'b0;
    data_en_d  = data_en_q;
    wdog_err_d = wdog_err_q;
    wdog_cnt_d = wdog_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        level_d   = '0;
        data_en_d = 1'b0;
        if (iRunStart) begin
          data_en_d  = 1'b1;
          wdog_err_d = 1'b0;
          state_d    = ST_ARB;
        end
      end

      ST_ARB: begin
        if (!iRunStart) begin
          data_en_d = 1'b0;
          state_d   = ST_DRAIN_ARB;
        end else if (wr_grant) begin
          wr_start_d = 1'b1;
          wr_addr_d  = wr_ptr_q;
          wr_num_d   = WR_NUM;
          wdog_cnt_d = '0;
          state_d    = ST_WR_WAIT;
        end else if (rd_grant) begin
          rd_start_d = 1'b1;
          rd_addr_d  = rd_ptr_q;
          rd_num_d   = RD_NUM;
          wdog_cnt_d = '0;
          state_d    = ST_RD_WAIT;
        end
      end

      ST_WR_WAIT: begin
        if (WR_RunEnd) begin
          wr_ptr_d = wr_ptr_q + wr_num_q;
          level_d  = level_q + {1'b0, wr_num_q};
          // A run stopped mid-burst goes straight to draining.
          if (iRunStart) begin
            state_d = ST_ARB;
          end else begin
            data_en_d = 1'b0;
            state_d   = ST_DRAIN_ARB;
          end
        end else if (wdog_trip) begin
          wdog_err_d = 1'b1;
          data_en_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 16'd1;
        end
      end

      ST_RD_WAIT: begin
        if (RD_RunEnd) begin
          rd_ptr_d = rd_ptr_q + rd_num_q;
          level_d  = level_q - {1'b0, rd_num_q};
          if (iRunStart) begin
            state_d = ST_ARB;
          end else begin
            data_en_d = 1'b0;
            state_d   = ST_DRAIN_ARB;
          end
        end else if (wdog_trip) begin
          wdog_err_d = 1'b1;
          data_en_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 16'd1;
        end
      end

      ST_DRAIN_ARB: begin
        // No new writes; empty the ring through the USB FIFO.
        if (level_q == '0) begin
          state_d = ST_IDLE;
        end else if (usb_ok) begin
          rd_start_d = 1'b1;
          rd_addr_d  = rd_ptr_q;
          rd_num_d   = drain_len(level_q, RD_BURST);
          wdog_cnt_d = '0;
          state_d    = ST_DRAIN_WAIT;
        end
      end

      ST_DRAIN_WAIT: begin
        if (RD_RunEnd) begin
          rd_ptr_d = rd_ptr_q + rd_num_q;
          level_d  = level_q - {1'b0, rd_num_q};
          state_d  = ST_DRAIN_ARB;
        end else if (wdog_trip) begin
          wdog_err_d = 1'b1;
          data_en_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_num_q   <= '0;
      rd_num_q   <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      data_en_q  <= 1'b0;
      wdog_err_q <= 1'b0;
      wdog_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_num_q   <= wr_num_d;
      rd_num_q   <= rd_num_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
      data_en_q  <= data_en_d;
      wdog_err_q <= wdog_err_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

  assign WR_iRunStart   = wr_start_q;
  assign RD_iRunStart   = rd_start_q;
  assign WR_START_ADDR  = wr_addr_q;
  assign RD_START_ADDR  = rd_addr_q;
  assign WR_DATA_NUM    = wr_num_q;
  assign RD_DATA_NUM    = rd_num_q;
  assign Data_iRunStart = data_en_q;
  assign sram_level     = level_q;
  assign sram_empty     = (level_q == '0);
  assign sram_full      = (32'(level_q) + WR_BURST > SRAM_DEPTH);
  assign wdog_err       = wdog_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sram_ring_scheduler.sv
// Bench for sram_ring_scheduler: randomized FIFO fills, a ring model kept
// as plain integers, and a scoreboard of expected burst descriptors that a
// monitor checks whenever a start pulse appears.
module tb_sram_ring_scheduler;
  import sram_ring_scheduler_pkg::*;

  localparam int WRB     = 1024;
  localparam int RDB     = 4096;
  localparam int DEPTH   = 32768;
  localparam int USB_MAX = 'h3000;
  localparam int WDOG    = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iRunStart;
  logic [10:0] SRAM_FIFO_usedw;
  logic [13:0] USB_FIFO_usedw;
  logic        WR_RunEnd;
  logic        RD_RunEnd;
  logic        WR_iRunStart, RD_iRunStart;
  logic [14:0] WR_START_ADDR, RD_START_ADDR, WR_DATA_NUM, RD_DATA_NUM;
  logic        Data_iRunStart;
  logic [15:0] sram_level;
  logic        sram_empty, sram_full, wdog_err;
  logic [2:0]  dbg_state;

  sram_ring_scheduler #(.WDOG_LIMIT(WDOG)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .iRunStart       (iRunStart),
    .SRAM_FIFO_usedw (SRAM_FIFO_usedw),
    .USB_FIFO_usedw  (USB_FIFO_usedw),
    .WR_RunEnd       (WR_RunEnd),
    .RD_RunEnd       (RD_RunEnd),
    .WR_iRunStart    (WR_iRunStart),
    .RD_iRunStart    (RD_iRunStart),
    .WR_START_ADDR   (WR_START_ADDR),
    .RD_START_ADDR   (RD_START_ADDR),
    .WR_DATA_NUM     (WR_DATA_NUM),
    .RD_DATA_NUM     (RD_DATA_NUM),
    .Data_iRunStart  (Data_iRunStart),
    .sram_level      (sram_level),
    .sram_empty      (sram_empty),
    .sram_full       (sram_full),
    .wdog_err        (wdog_err),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  bit mon_en = 1'b0;
  logic [30:0] exp_q[$];      // {is_rd, start_addr, data_num}
  logic [30:0] mon_got, mon_exp;

  // Ring model: occupancy and pointers as plain integers.
  int m_level  = 0;
  int m_wr_ptr = 0;
  int m_rd_ptr = 0;
  bit m_last_rd = 1'b1;
  bit m_run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && (WR_iRunStart || RD_iRunStart)) begin
      chk("one_side_pulse", {31'b0, WR_iRunStart & RD_iRunStart}, 32'd0);
      mon_got = RD_iRunStart ? {1'b1, RD_START_ADDR, RD_DATA_NUM}
                             : {1'b0, WR_START_ADDR, WR_DATA_NUM};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_burst: got 0x%0h, expected no burst", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("burst_desc", {1'b0, mon_got}, {1'b0, mon_exp});
      end
      pulse_cnt++;
    end
  end

  // ---------------- reference model ----------------
  // Decides the next burst from the current FIFO fills and ring occupancy.
  function automatic bit predict(output bit is_rd, output int num);
    int  sram, usb;
    bit  wr_ok, rd_ok;
    sram  = int'(SRAM_FIFO_usedw);
    usb   = int'(USB_FIFO_usedw);
    is_rd = 1'b0;
    num   = 0;
    if (m_run) begin
      wr_ok = (sram >= WRB) && (m_level + WRB <= DEPTH);
      rd_ok = (m_level >= RDB) && (usb <= USB_MAX);
      if (wr_ok && rd_ok) is_rd = !m_last_rd;
      else if (wr_ok)     is_rd = 1'b0;
      else if (rd_ok)     is_rd = 1'b1;
      else                return 1'b0;
      num = is_rd ? RDB : WRB;
      return 1'b1;
    end
    if (m_level == 0 || usb > USB_MAX) return 1'b0;
    is_rd = 1'b1;
    num   = (m_level < RDB) ? m_level : RDB;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pick_inputs(input int mode);
    bit r;
    int n;
    case (mode)
      0: begin SRAM_FIFO_usedw = 11'd1024; USB_FIFO_usedw = 14'd0; end
      1: begin
        SRAM_FIFO_usedw = 11'($urandom_range(1024, 2047));
        USB_FIFO_usedw  = 14'($urandom_range(USB_MAX + 1, 'h3fff));
      end
      2: begin
        SRAM_FIFO_usedw = 11'($urandom_range(0, 2047));
        USB_FIFO_usedw  = 14'($urandom_range('h2800, 'h3fff));
      end
      3: begin
        SRAM_FIFO_usedw = 11'($urandom_range(0, 1023));
        USB_FIFO_usedw  = 14'(USB_MAX + 1);
      end
      default: begin
        SRAM_FIFO_usedw = 11'($urandom_range(0, 2047));
        USB_FIFO_usedw  = 14'($urandom_range(0, USB_MAX));
      end
    endcase
    // Keep the random phases moving: make sure some side is eligible.
    if (mode != 3 && m_run && !predict(r, n)) begin
      if (m_level + WRB <= DEPTH) SRAM_FIFO_usedw = 11'd1024;
      else                        USB_FIFO_usedw  = 14'($urandom_range(0, USB_MAX));
    end
  endtask

  task automatic start_run(input int sram, input int usb);
    @(posedge clk); #1;
    SRAM_FIFO_usedw = 11'(sram);
    USB_FIFO_usedw  = 14'(usb);
    iRunStart = 1'b1;
    m_level = 0; m_wr_ptr = 0; m_rd_ptr = 0; m_run = 1'b1;
  endtask

  task automatic issue(output bit is_rd, output int num);
    int start;
    bit seen;
    if (!predict(is_rd, num)) begin
      n_checks++;
      n_fail++;
      $display("FAIL model_grant: got no eligible burst, expected one");
      return;
    end
    exp_q.push_back({is_rd, 15'(is_rd ? m_rd_ptr : m_wr_ptr), 15'(num)});
    if (m_run) m_last_rd = is_rd;
    start = pulse_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      seen = (pulse_cnt != start);
    end
    chk("grant_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic finish(input bit is_rd, input int num, input int mode, input bit next_run);
    repeat ($urandom_range(0, 6)) @(posedge clk);
    @(posedge clk); #1;
    if (is_rd) begin
      m_rd_ptr = (m_rd_ptr + num) % DEPTH;
      m_level  = m_level - num;
    end else begin
      m_wr_ptr = (m_wr_ptr + num) % DEPTH;
      m_level  = m_level + num;
    end
    m_run = next_run;
    iRunStart = next_run;
    pick_inputs(mode);
    if (is_rd) RD_RunEnd = 1'b1;
    else       WR_RunEnd = 1'b1;
    @(posedge clk); #1;
    WR_RunEnd = 1'b0;
    RD_RunEnd = 1'b0;
    @(negedge clk);
    chk("level",      {16'b0, sram_level}, 32'(m_level));
    chk("empty",      {31'b0, sram_empty}, 32'(m_level == 0));
    chk("full",       {31'b0, sram_full},  32'(m_level + WRB > DEPTH));
    chk("data_en",    {31'b0, Data_iRunStart}, 32'(m_run));
  endtask

  task automatic step(input int mode, input bit next_run);
    bit r;
    int n;
    issue(r, n);
    finish(r, n, mode, next_run);
  endtask

  task automatic expect_idle();
    @(posedge clk);
    @(negedge clk);
    chk("state_idle", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    chk("idle_empty", {31'b0, sram_empty}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int quiet_start;
    bit r;
    int n;
    reset_n = 1'b0; iRunStart = 1'b0;
    SRAM_FIFO_usedw = '0; USB_FIFO_usedw = '0;
    WR_RunEnd = 1'b0; RD_RunEnd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state",   {29'b0, dbg_state}, {29'b0, ST_IDLE});
    chk("rst_wr_puls", {31'b0, WR_iRunStart}, 32'd0);
    chk("rst_rd_puls", {31'b0, RD_iRunStart}, 32'd0);
    chk("rst_data_en", {31'b0, Data_iRunStart}, 32'd0);
    chk("rst_wdog",    {31'b0, wdog_err}, 32'd0);
    chk("rst_level",   {16'b0, sram_level}, 32'd0);
    chk("rst_empty",   {31'b0, sram_empty}, 32'd1);
    chk("rst_full",    {31'b0, sram_full}, 32'd0);
    chk("rst_desc",    {2'b0, WR_START_ADDR, WR_DATA_NUM}, 32'd0);
    chk("rst_desc_rd", {2'b0, RD_START_ADDR, RD_DATA_NUM}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // First write at address 0, then write/read alternation once 4096 held.
    start_run(1024, 0);
    repeat (8) step(0, 1'b1);

    // Fill past the ring size with reads held off: pointer wrap and full flag.
    repeat (44) step(1, 1'b1);
    step(3, 1'b1);

    // USB FIFO one above threshold and no write data: nothing may start.
    quiet_start = pulse_cnt;
    repeat (30) @(posedge clk);
    chk("usb_block", 32'(pulse_cnt), 32'(quiet_start));
    #1 USB_FIFO_usedw = 14'(USB_MAX);
    step(2, 1'b1);

    // Random mixed traffic, then stop the run and drain.
    repeat (59) step(2, 1'b1);
    step(4, 1'b0);
    while (m_level > 0) step(4, 1'b0);
    expect_idle();

    // Five writes (5120 words), stop: drain reads 4096 then 1024.
    start_run(1024, USB_MAX + 1);
    repeat (4) step(1, 1'b1);
    step(4, 1'b0);
    while (m_level > 0) step(4, 1'b0);
    expect_idle();

    // Stray read completion while arbitrating changes nothing.
    start_run(0, 0);
    repeat (4) @(posedge clk);
    quiet_start = pulse_cnt;
    #1 RD_RunEnd = 1'b1;
    @(posedge clk); #1 RD_RunEnd = 1'b0;
    @(negedge clk);
    chk("stray_state", {29'b0, dbg_state}, {29'b0, ST_ARB});
    chk("stray_level", {16'b0, sram_level}, 32'd0);
    chk("stray_pulse", 32'(pulse_cnt), 32'(quiet_start));

    // Withhold the write completion until the watchdog fires.
    @(posedge clk); #1 SRAM_FIFO_usedw = 11'd1024;
    issue(r, n);
    #1 iRunStart = 1'b0;
    repeat (WDOG - 1) @(negedge clk);
    chk("wdog_before", {31'b0, wdog_err}, 32'd0);
    @(negedge clk);
    chk("wdog_err",     {31'b0, wdog_err}, 32'd1);
    chk("wdog_state",   {29'b0, dbg_state}, {29'b0, ST_IDLE});
    chk("wdog_data_en", {31'b0, Data_iRunStart}, 32'd0);
    @(posedge clk); #1 WR_RunEnd = 1'b1; SRAM_FIFO_usedw = 11'd0;
    @(posedge clk); #1 WR_RunEnd = 1'b0;
    @(negedge clk);
    chk("late_end_level", {16'b0, sram_level}, 32'd0);
    chk("wdog_sticky",    {31'b0, wdog_err}, 32'd1);
    @(posedge clk); #1 iRunStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_wdog",  {31'b0, wdog_err}, 32'd0);
    chk("restart_data",  {31'b0, Data_iRunStart}, 32'd1);
    chk("restart_state", {29'b0, dbg_state}, {29'b0, ST_ARB});

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
